spi_peri_rx_mode: RTL

//  Parametrised, system-clocked SPI peripheral for the comm module. It oversamples the

---
 rtl/spi_peri_rx_mode.sv | 202 ++++++++++++++++++++
 1 files changed

// File: rtl/spi_peri_rx_mode.sv
// spi_peri_rx_mode: system-clocked SPI peripheral (all CPOL/CPHA modes).
// SCLK, MOSI and CS_n are oversampled through synchronisers. Received words go into
// an RX FIFO, and TX words come from a single holding register.
module spi_peri_rx_mode #(
  parameter int DATA_W      = 8,
  parameter int CPOL        = 0,
  parameter int CPHA        = 0,
  parameter int MSB_FIRST   = 1,
  parameter int FIFO_DEPTH  = 4,
  parameter int SYNC_STAGES = 2
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        spi_sclk,
  input  logic                        spi_mosi,
  input  logic                        spi_cs_n,
  output logic                        spi_miso,
  output logic                        spi_miso_oe,
  input  logic [DATA_W-1:0]           tx_data,
  input  logic                        tx_valid,
  output logic                        tx_ready,
  output logic [DATA_W-1:0]           rx_data,
  output logic                        rx_valid,
  input  logic                        rx_ready,
  output logic [$clog2(FIFO_DEPTH):0] rx_level,
  output logic                        rx_overflow,
  input  logic                        ovf_clr,
  output logic                        frame_err,
  output logic                        tx_underrun,
  output logic                        busy
);
  localparam int   AW        = $clog2(FIFO_DEPTH);
  localparam int   CW        = $clog2(DATA_W);
  localparam logic SCLK_IDLE = (CPOL != 0);
  localparam logic PHASE1    = (CPHA != 0);
  localparam logic MSB1      = (MSB_FIRST != 0);

  typedef enum logic {IDLE, SHIFT} state_t;

  state_t                   state, state_next;
  logic [SYNC_STAGES-1:0]   sclk_sync, mosi_sync, cs_sync;
  logic                     sclk_s, mosi_s, cs_s, sclk_prev, cs_prev;
  logic                     lead_edge, trail_edge, sample_edge, shift_edge;
  logic                     cs_fall, cs_rise, in_shift, start, frame_end;
  logic                     do_sample, do_shift, word_done, consume, last_bit;
  logic [CW-1:0]            bit_cnt;
  logic [DATA_W-1:0]        rx_shift, rx_next, tx_shift, hold_data;
  logic                     hold_full, hold_first, miso_bit;
  logic [DATA_W-1:0]        mem [FIFO_DEPTH];
  logic [AW-1:0]            wr_ptr, rd_ptr;
  logic [AW:0]              count;
  logic                     fifo_full, pop, push_ok;

  // Synchronisers reset to the idle bus levels so no false edge appears after reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sclk_sync <= {SYNC_STAGES{SCLK_IDLE}};
      mosi_sync <= '0;
      cs_sync   <= '1;
      sclk_prev <= SCLK_IDLE;
      cs_prev   <= 1'b1;
    end else begin
      sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], spi_sclk};
      mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], spi_mosi};
      cs_sync   <= {cs_sync[SYNC_STAGES-2:0], spi_cs_n};
      sclk_prev <= sclk_s;
      cs_prev   <= cs_s;
    end
  end

  assign sclk_s      = sclk_sync[SYNC_STAGES-1];
  assign mosi_s      = mosi_sync[SYNC_STAGES-1];
  assign cs_s        = cs_sync[SYNC_STAGES-1];
  assign lead_edge   = (sclk_s != sclk_prev) && (sclk_s != SCLK_IDLE) && !cs_s;
  assign trail_edge  = (sclk_s != sclk_prev) && (sclk_s == SCLK_IDLE) && !cs_s;
  assign sample_edge = PHASE1 ? trail_edge : lead_edge;
  assign shift_edge  = PHASE1 ? lead_edge : trail_edge;
  assign cs_fall     = cs_prev && !cs_s;
  assign cs_rise     = !cs_prev && cs_s;

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  // Next state plus the per-cycle control strobes derived from it.
  always_comb begin
    state_next = state;
    in_shift   = (state == SHIFT);
    start      = 1'b0;
    frame_end  = 1'b0;
    case (state)
      IDLE: if (cs_fall) begin
        state_next = SHIFT;
        start      = 1'b1;
      end
      SHIFT: if (cs_rise) begin
        state_next = IDLE;
        frame_end  = 1'b1;
      end
      default: state_next = IDLE;
    endcase
    last_bit  = (bit_cnt == CW'(DATA_W - 1));
    do_sample = in_shift && sample_edge;
    do_shift  = in_shift && shift_edge;
    word_done = do_sample && last_bit;
    consume   = start || word_done;
    rx_next   = MSB1 ? {rx_shift[DATA_W-2:0], mosi_s} : {mosi_s, rx_shift[DATA_W-1:1]};
  end

  // Receive shifter and bit counter; a CS rise throws any partial word away.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bit_cnt   <= '0;
      rx_shift  <= '0;
      frame_err <= 1'b0;
    end else begin
      frame_err <= frame_end && (bit_cnt != '0);
      if (start || frame_end) begin
        bit_cnt  <= '0;
        rx_shift <= '0;
      end else if (do_sample) begin
        rx_shift <= rx_next;
        bit_cnt  <= last_bit ? '0 : bit_cnt + CW'(1);
      end
    end
  end

  // Transmit shifter: hold_first suppresses the one shift edge that must present bit 0 instead.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tx_shift    <= '0;
      hold_first  <= 1'b0;
      tx_underrun <= 1'b0;
    end else begin
      tx_underrun <= consume && !hold_full;
      if (consume) begin
        tx_shift   <= hold_full ? hold_data : '0;
        hold_first <= PHASE1 || word_done;
      end else if (do_shift) begin
        if (hold_first) hold_first <= 1'b0;
        else if (MSB1)  tx_shift   <= {tx_shift[DATA_W-2:0], 1'b0};
        else            tx_shift   <= {1'b0, tx_shift[DATA_W-1:1]};
      end
    end
  end

  // TX holding register; a same-cycle consume sees the old contents, the load wins.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hold_full <= 1'b0;
      hold_data <= '0;
    end else begin
      if (consume) hold_full <= 1'b0;
      if (tx_valid && tx_ready) begin
        hold_full <= 1'b1;
        hold_data <= tx_data;
      end
    end
  end

  assign tx_ready    = !hold_full;
  assign miso_bit    = MSB1 ? tx_shift[DATA_W-1] : tx_shift[0];
  assign spi_miso    = in_shift && !(PHASE1 && hold_first) && miso_bit;
  assign spi_miso_oe = in_shift;
  assign busy        = in_shift;

  assign fifo_full = (count == (AW+1)'(FIFO_DEPTH));
  assign pop       = rx_valid && rx_ready;
  assign push_ok   = word_done && (!fifo_full || pop);

  // FIFO storage, written with the word completed on this sample edge.
  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= rx_next;
  end

  // FIFO pointers, occupancy and the sticky overflow flag (set beats clear).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      count       <= '0;
      rx_overflow <= 1'b0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + AW'(1);
      if (pop)     rd_ptr <= rd_ptr + AW'(1);
      case ({push_ok, pop})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
      if (word_done && fifo_full && !pop) rx_overflow <= 1'b1;
      else if (ovf_clr)                   rx_overflow <= 1'b0;
    end
  end

  assign rx_data  = mem[rd_ptr];
  assign rx_valid = (count != '0);
  assign rx_level = count;

endmodule
